// File: rtl/fib_pkg.sv
// fib_pkg: shared types and defaults for the Fibonacci RAM initiator.
//   state_t : controller state encoding (IDLE, WRITE, READ, DONE)
//   N_DEF   : default RAM address width
//   M_DEF   : default RAM / term data width
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEF = 6;
  localparam int M_DEF = 8;

endpackage

// File: rtl/fib_ram_ctrl_term_gen.sv
// fib_term_gen: Fibonacci term generator (a, b pair with an M-bit adder).
//   clk, reset : clock, synchronous active-high reset (clears a and b)
//   load       : a <= 0, b <= 1 (start of a run)
//   adv        : a <= b, b <= (a + b) mod 2**M
//   a          : current term
//   carry      : carry out of a + b for the current pair
module fib_term_gen
  import fib_pkg::*;
#(
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         adv,
  output logic [M-1:0] a,
  output logic         carry
);

  logic [M-1:0] b;
  logic [M:0]   sum;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign carry = sum[M];

  always_ff @(posedge clk) begin
    if (reset) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= '0;
      b <= M'(1);
    end else if (adv) begin
      a <= b;
      b <= sum[M-1:0];
    end
  end

endmodule

// File: rtl/fib_ram_ctrl.sv
// fib_ram_ctrl: writes a run of Fibonacci terms into a single-port RAM
// (sync write, async read) from address 0, then streams them back out.
//   clk, reset          : clock, synchronous active-high reset
//   start, len          : run request (sampled in IDLE); run is len+1 terms
//   ram_addr/din/we     : RAM write/read port, driven only by this block
//   ram_dout            : RAM asynchronous read data
//   out_data/valid/ready: read-back stream
//   busy                : high in WRITE and READ
//   done                : one-cycle pulse after the last transfer
//   ovf                 : sticky, a written term exceeded M bits this run
module fib_ram_ctrl
  import fib_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] len,
  output logic [N-1:0] ram_addr,
  output logic [M-1:0] ram_din,
  output logic         ram_we,
  input  logic [M-1:0] ram_dout,
  output logic [M-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         ovf
);

  state_t       state, state_nxt;
  logic [N-1:0] idx;
  logic [N-1:0] last;
  logic [M-1:0] term_a;
  logic         term_carry;
  logic         at_last;
  logic         sum_written;

  assign at_last = (idx == last);

  // The pair (a, b) at idx is (F(idx), F(idx+1)); a + b is F(idx+2), which
  // only lands in the RAM when idx+2 <= last. Compare one bit wider so the
  // +2 cannot wrap.
  assign sum_written = (({1'b0, idx} + (N+1)'(2)) <= {1'b0, last});

  fib_term_gen #(.M(M)) u_term_gen (
    .clk   (clk),
    .reset (reset),
    .load  ((state == IDLE) && start),
    .adv   (state == WRITE),
    .a     (term_a),
    .carry (term_carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            last <= len;
            idx  <= '0;
            ovf  <= 1'b0;
          end
        end
        WRITE: begin
          idx <= at_last ? '0 : idx + N'(1);
          if (term_carry && sum_written) ovf <= 1'b1;
        end
        READ: begin
          if (out_ready) idx <= at_last ? '0 : idx + N'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = WRITE;
      WRITE:   if (at_last) state_nxt = READ;
      READ:    if (out_ready && at_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_addr  = '0;
    ram_din   = '0;
    ram_we    = 1'b0;
    out_data  = '0;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      WRITE: begin
        ram_addr = idx;
        ram_din  = term_a;
        ram_we   = 1'b1;
        busy     = 1'b1;
      end
      READ: begin
        ram_addr  = idx;
        out_data  = ram_dout;
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule
